// File: rtl/imm_pkg.sv
// Shared immediate-format encoding and RV opcode constants for the immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    FmtNone = 3'd0,
    FmtI    = 3'd1,
    FmtS    = 3'd2,
    FmtB    = 3'd3,
    FmtU    = 3'd4,
    FmtJ    = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode decode and immediate extraction, sign-extended to XLEN bits.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  imm_fmt_e    fmt;
  logic [31:0] imm32;

  always_comb begin
    fmt       = FmtNone;
    illegal_o = 1'b0;
    unique case (instr_i[6:0])
      OpLoad, OpImm, OpImm32, OpJalr: fmt = FmtI;
      OpStore:                        fmt = FmtS;
      OpBranch:                       fmt = FmtB;
      OpLui, OpAuipc:                 fmt = FmtU;
      OpJal:                          fmt = FmtJ;
      default:                        illegal_o = 1'b1;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (fmt)
      FmtI: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      FmtS: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FmtB: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                     instr_i[11:8], 1'b0};
      FmtU: imm32 = {instr_i[31:12], 12'b0};
      FmtJ: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                     instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // imm32 is already sign-correct; widen by replicating its top bit.
  always_comb begin
    imm_o        = '0;
    imm_o[31:0]  = imm32;
    for (int unsigned b = 32; b < XLEN; b++) begin
      imm_o[b] = imm32[31];
    end
  end

  assign fmt_o = fmt;

endmodule

// File: rtl/imm_gen_pipe.sv
// One-stage valid/ready immediate generator with a saturating illegal-opcode counter.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;
  logic             dec_illegal;
  logic             accept;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic [2:0]       out_fmt_q, out_fmt_d;
  logic             out_illegal_q, out_illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr_i   (in_instr),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  assign in_ready = !reset && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_imm_d     = out_imm_q;
    out_fmt_d     = out_fmt_q;
    out_illegal_d = out_illegal_q;
    if (accept) begin
      out_valid_d   = 1'b1;
      out_imm_d     = dec_imm;
      out_fmt_d     = dec_fmt;
      out_illegal_d = dec_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear wins over a same-cycle increment; saturate instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept && dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_imm_q     <= '0;
      out_fmt_q     <= FmtNone;
      out_illegal_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_imm_q     <= out_imm_d;
      out_fmt_q     <= out_fmt_d;
      out_illegal_q <= out_illegal_d;
      cnt_q         <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_illegal_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: a 64-bit/2-bit-counter instance and a 32-bit instance share one input stream.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;

  logic        in_ready, out_valid, out_illegal;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic [1:0]  illegal_cnt;

  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [31:0] b_out_imm;
  logic [2:0]  b_out_fmt;
  logic [15:0] b_illegal_cnt;

  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal),
    .cnt_clr(cnt_clr), .illegal_cnt(illegal_cnt)
  );

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal),
    .cnt_clr(cnt_clr), .illegal_cnt(b_illegal_cnt)
  );

  typedef struct {
    logic [63:0] imm;
    int          fmt;
    bit          ill;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nfail = 0;
  bit   ov_m = 1'b0;
  int   cnt_m = 0;
  int   cnt32_m = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: format from an opcode table, value from weighted immediate fields.
  function automatic int fmt_of(input logic [31:0] x);
    case (x[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67: return 1;
      7'h23: return 2;
      7'h63: return 3;
      7'h37, 7'h17: return 4;
      7'h6F: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic longint imm_of(input logic [31:0] x);
    longint s = x[31] ? 64'sd1 : 64'sd0;
    case (fmt_of(x))
      1: return -s * 2048 + longint'(x[30:20]);
      2: return -s * 2048 + longint'(x[30:25]) * 32 + longint'(x[11:7]);
      3: return -s * 4096 + longint'(x[7]) * 2048 + longint'(x[30:25]) * 32
                + longint'(x[11:8]) * 2;
      4: return -s * (64'sd1 << 31) + longint'(x[30:12]) * 4096;
      5: return -s * (64'sd1 << 20) + longint'(x[19:12]) * 4096 + longint'(x[20]) * 2048
                + longint'(x[30:21]) * 2;
      default: return 0;
    endcase
  endfunction

  wire acc_m = !reset && in_valid && (!ov_m || out_ready);

  always @(posedge clk) begin
    if (reset) begin
      sb.delete();
      ov_m    <= 1'b0;
      cnt_m   <= 0;
      cnt32_m <= 0;
    end else begin
      if (acc_m) sb.push_back('{imm: imm_of(in_instr), fmt: fmt_of(in_instr),
                                ill: (fmt_of(in_instr) == 0)});
      if (cnt_clr) begin
        cnt_m   <= 0;
        cnt32_m <= 0;
      end else if (acc_m && fmt_of(in_instr) == 0) begin
        cnt_m   <= (cnt_m < 3) ? cnt_m + 1 : 3;
        cnt32_m <= (cnt32_m < 65535) ? cnt32_m + 1 : 65535;
      end
      ov_m <= acc_m ? 1'b1 : (out_ready ? 1'b0 : ov_m);
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, ov_m);
    chk("out_valid32", b_out_valid, ov_m);
    chk("in_ready", in_ready, !reset && (!ov_m || out_ready));
    chk("in_ready32", b_in_ready, !reset && (!ov_m || out_ready));
    chk("illegal_cnt", illegal_cnt, cnt_m);
    chk("illegal_cnt32", b_illegal_cnt, cnt32_m);
    if (ov_m) begin
      if (sb.size() != 1) begin
        chk("sb_level", sb.size(), 1);
      end else begin
        chk("out_imm", out_imm, sb[0].imm);
        chk("out_imm32", b_out_imm, {32'b0, sb[0].imm[31:0]});
        chk("out_fmt", out_fmt, sb[0].fmt);
        chk("out_fmt32", b_out_fmt, sb[0].fmt);
        chk("out_illegal", out_illegal, sb[0].ill);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic drive(input bit iv, input logic [31:0] ins, input bit ordy, input bit clr);
    in_valid  = iv;
    in_instr  = ins;
    out_ready = ordy;
    cnt_clr   = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] ops [9] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
  int         exp_cnt [5] = '{1, 2, 3, 3, 3};

  initial begin
    logic [31:0] r;
    reset = 1'b1;
    drive(0, '0, 1, 0);
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_fmt", out_fmt, 0);
    chk("rst_illegal", out_illegal, 0);
    chk("rst_cnt", illegal_cnt, 0);
    chk("rst_imm32", b_out_imm, 0);
    reset = 1'b0;

    drive(1, 32'hFF813083, 1, 0); tick();
    chk("ld_valid", out_valid, 1);
    chk("ld_imm", out_imm, 64'hFFFFFFFFFFFFFFF8);
    chk("ld_fmt", out_fmt, 1);
    drive(1, 32'hFE113823, 1, 0); tick();
    chk("st_imm", out_imm, 64'hFFFFFFFFFFFFFFF0);
    chk("st_fmt", out_fmt, 2);
    drive(1, 32'hFE000EE3, 1, 0); tick();
    chk("br_imm", out_imm, 64'hFFFFFFFFFFFFFFFC);
    chk("br_fmt", out_fmt, 3);
    drive(1, 32'h0010006F, 1, 0); tick();
    chk("jal_imm", out_imm, 64'h800);
    chk("jal_fmt", out_fmt, 5);
    drive(1, 32'h800000B7, 1, 0); tick();
    chk("lui_imm64", out_imm, 64'hFFFFFFFF80000000);
    chk("lui_imm32", b_out_imm, 32'h80000000);
    chk("lui_fmt", out_fmt, 4);

    // Backpressure: LUI result held while a new word waits.
    drive(1, 32'h00A00093, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", in_ready, 0);
      tick();
      chk("bp_hold_imm", out_imm, 64'hFFFFFFFF80000000);
      chk("bp_hold_valid", out_valid, 1);
    end
    drive(1, 32'h00A00093, 1, 0);
    #1 chk("bp_release_ready", in_ready, 1);
    tick();
    chk("bp_new_imm", out_imm, 64'hA);
    chk("bp_new_valid", out_valid, 1);

    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h0, 1, 0); tick();
      chk("ill_flag", out_illegal, 1);
      chk("ill_cnt_seq", illegal_cnt, exp_cnt[i]);
    end
    drive(1, 32'h0, 1, 1); tick();
    chk("ill_clr", illegal_cnt, 0);

    // Reset while a result is held: it must vanish.
    drive(1, 32'h0, 1, 0); tick();
    drive(0, '0, 0, 0); tick();
    chk("held_valid", out_valid, 1);
    chk("held_cnt", illegal_cnt, 1);
    reset = 1'b1; tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", illegal_cnt, 0);
    reset = 1'b0;
    drive(0, '0, 1, 0);
    repeat (3) tick();
    chk("post_rst_valid", out_valid, 0);

    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      if ($urandom_range(7) != 0) r[6:0] = ops[$urandom_range(8)];
      drive($urandom_range(3) != 0, r, $urandom_range(3) != 0, $urandom_range(31) == 0);
      tick();
    end

    drive(0, '0, 1, 0);
    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning the output immediate width; legal values are 32 and 64.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the illegal-opcode counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning an instruction word is offered.
REQ-006 SHALL have port in_instr, input, 32, the raw instruction word.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts in_instr this cycle.
REQ-008 SHALL have port out_valid, output, 1, meaning the out_* fields hold a result.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-010 SHALL have port out_imm, output, XLEN, the sign-extended immediate.
REQ-011 SHALL have port out_fmt, output, 3, the imm_fmt_e code {NONE, I, S, B, U, J}.
REQ-012 SHALL have port out_illegal, output, 1, meaning the opcode is unrecognised.
REQ-013 SHALL have port cnt_clr, input, 1, a synchronous clear of the illegal counter.
REQ-014 SHALL have port illegal_cnt, output, CNT_W, the count of accepted illegal opcodes.

Function
REQ-015 SHALL decode opcode in_instr[6:0] as follows: I for 0000011, 0010011, 0011011 and 1100111; S for 0100011; B for 1100011; U for 0110111 and 0010111; J for 1101111; every other value is NONE with illegal=1.
REQ-016 SHALL form I as sext(in[31:20]) and S as sext({in[31:25],in[11:7]}).
REQ-017 SHALL form B as sext({in[31],in[7],in[30:25],in[11:8],1'b0}), a byte offset with LSB 0.
REQ-018 SHALL form U as sext({in[31:12],12'b0}) and J as sext({in[31],in[19:12],in[20],in[30:21],1'b0}).
REQ-019 SHALL drive out_imm=0 for NONE; every sign extension replicates in[31] up to bit XLEN-1.
REQ-020 SHALL be a single register stage: a transfer accepted in cycle N appears on out_* with out_valid=1 in cycle N+1.
REQ-021 SHALL accept input only when in_valid && in_ready.
REQ-022 SHALL drive in_ready = !out_valid || out_ready combinationally, with in_ready=0 while reset=1.
REQ-023 SHALL allow simultaneous output drain and input accept, sustaining full throughput of one instruction per cycle.
REQ-024 SHALL hold out_* stable while out_valid && !out_ready.
REQ-025 SHALL clear out_valid after a drain that has no accept in the same cycle.
REQ-026 SHALL increment illegal_cnt by 1 per accepted illegal instruction, saturating at 2^CNT_W-1 with no wrap.
REQ-027 SHALL give cnt_clr priority over a simultaneous increment, yielding illegal_cnt=0.

Reset
REQ-028 SHALL, on reset, set out_valid=0, out_imm=0, out_fmt=NONE, out_illegal=0 and illegal_cnt=0.
REQ-029 SHALL discard any held result when reset is asserted mid-operation, with no residual transfer afterwards.

Structure
REQ-030 SHALL place imm_fmt_e and the opcode constants in the shared package imm_pkg.
REQ-031 SHALL implement decode and extension in a combinational sub-module imm_decode (instr -> imm, fmt, illegal); imm_gen_pipe SHALL hold the register stage and the counter.

Verification
REQ-032 SHALL cover the load/store case with XLEN=64: 0xFF813083 -> I with out_imm 0xFFFFFFFFFFFFFFF8, then 0xFE113823 -> S with out_imm 0xFFFFFFFFFFFFFFF0, each one cycle after acceptance.
REQ-033 SHALL cover the branch/jump case: 0xFE000EE3 -> B with out_imm 0xFFFFFFFFFFFFFFFC, and 0x0010006F -> J with out_imm 0x800.
REQ-034 SHALL cover the U-type case: 0x800000B7 -> out_imm 0xFFFFFFFF80000000 at XLEN=64 and 0x80000000 at XLEN=32.
REQ-035 SHALL cover backpressure: out_ready low for 3 cycles with in_valid high -> out_* stable and in_ready=0; when out_ready rises, drain and accept occur in the same cycle.
REQ-036 SHALL cover the illegal counter with CNT_W=2: five accepted 0x00000000 words -> out_illegal=1 and illegal_cnt 1,2,3,3,3; cnt_clr together with a sixth illegal word -> illegal_cnt 0.
REQ-037 SHALL cover reset while out_valid=1 and out_ready=0 -> out_valid=0 and illegal_cnt=0 the next cycle, with the held result never delivered.
